// File: rtl/flash_shift_pkg.sv
// Shared encodings for the flash_shift register file and pattern engine.
package flash_shift_pkg;

    // Mode field, CTRL[1:0]
    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STATIC = 2'b01;
    localparam logic [1:0] MODE_FLASH  = 2'b10;
    localparam logic [1:0] MODE_SHIFT  = 2'b11;

    // CTRL single-bit fields
    localparam int CTRL_DIR_BIT     = 2;  // 0 rotate left, 1 rotate right
    localparam int CTRL_ONESHOT_BIT = 3;  // stop after one full rotation (SHIFT only)

    // Engine states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Register offsets shared with the AXI4-Lite register file
    localparam logic [3:0] REG_CTRL_OFFSET    = 4'h0;
    localparam logic [3:0] REG_PERIOD_OFFSET  = 4'h4;
    localparam logic [3:0] REG_PATTERN_OFFSET = 4'h8;
    localparam logic [3:0] REG_SPARE_OFFSET   = 4'hC;

endpackage

// File: rtl/flash_shift_prescaler.sv
// Free-running prescaler: counts 0..terminal and pulses tick on the terminal
// count. Clear has priority and suppresses the tick in the same cycle.
module flash_shift_prescaler #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] terminal,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] count;

    // Combinational expiry so tick, LED update and step count share one edge
    assign tick = enable && !clear && (count == terminal);

    // Counter: clear wins, wrap to zero at terminal, otherwise increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == terminal) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_shift_engine.sv
// LED pattern engine: shadows CTRL/PERIOD/PATTERN on cfg_update and drives
// the LEDs in OFF, STATIC, FLASH or rotating SHIFT mode, paced by a prescaler.
//
// Handshake: there is no valid/ready pair; cfg_update is a single-cycle
// strobe that is always accepted on the edge where it is high, and it takes
// priority over any prescaler expiry in the same cycle.
module flash_shift_engine
    import flash_shift_pkg::*;
#(
    parameter int LED_WIDTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          ctrl_reg,
    input  logic [31:0]          period_reg,
    input  logic [31:0]          pattern_reg,
    input  logic                 cfg_update,
    output logic [LED_WIDTH-1:0] led,
    output logic                 tick,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          step_count,
    output logic [1:0]           debug_state
);

    logic [3:0]           act_ctrl;
    logic [CNT_WIDTH-1:0] act_period;
    logic [LED_WIDTH-1:0] act_pattern;
    state_t               state;
    state_t               state_next;
    logic                 presc_clear;
    logic                 last_tick;
    logic [1:0]           new_mode;
    logic [1:0]           act_mode;

    assign new_mode    = ctrl_reg[1:0];
    assign act_mode    = act_ctrl[1:0];
    assign busy        = (state == RUN);
    assign debug_state = state;
    assign presc_clear = cfg_update || (state != RUN);

    // Final tick of a one-shot SHIFT: LED_WIDTH-1 ticks already counted
    assign last_tick = tick && (act_mode == MODE_SHIFT) && act_ctrl[CTRL_ONESHOT_BIT]
                       && (step_count == 16'(LED_WIDTH - 1));

    // Register-value bits this engine never looks at
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_reg[31:4];
    if (CNT_WIDTH < 32) begin : g_period_unused
        logic unused_period;
        assign unused_period = ^period_reg[31:CNT_WIDTH];
    end
    if (LED_WIDTH < 32) begin : g_pattern_unused
        logic unused_pattern;
        assign unused_pattern = ^pattern_reg[31:LED_WIDTH];
    end

    flash_shift_prescaler #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_prescaler (
        .clk      (ACLK),
        .rst      (ARESET),
        .clear    (presc_clear),
        .enable   (busy),
        .terminal (act_period),
        .tick     (tick)
    );

    // Shadow registers: only the update strobe changes the active set
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            act_ctrl    <= '0;
            act_period  <= '0;
            act_pattern <= '0;
        end else if (cfg_update) begin
            act_ctrl    <= ctrl_reg[3:0];
            act_period  <= period_reg[CNT_WIDTH-1:0];
            act_pattern <= pattern_reg[LED_WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: an update restarts from any state; one-shot ends in DONE
    always_comb begin
        state_next = state;
        if (cfg_update) begin
            state_next = (new_mode == MODE_OFF) ? IDLE : RUN;
        end else if ((state == RUN) && last_tick) begin
            state_next = DONE;
        end
    end

    // LED datapath: load on update, toggle or rotate on each tick
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            led <= '0;
        end else if (cfg_update) begin
            led <= (new_mode == MODE_OFF) ? '0 : pattern_reg[LED_WIDTH-1:0];
        end else if (tick) begin
            case (act_mode)
                MODE_FLASH: led <= led ^ act_pattern;
                MODE_SHIFT: begin
                    if (act_ctrl[CTRL_DIR_BIT]) begin
                        led <= {led[0], led[LED_WIDTH-1:1]};
                    end else begin
                        led <= {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
                    end
                end
                default: led <= led;
            endcase
        end
    end

    // Tick counter since the last update; wraps naturally at 16 bits
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            step_count <= '0;
        end else if (cfg_update) begin
            step_count <= '0;
        end else if (tick) begin
            step_count <= step_count + 16'd1;
        end
    end

    // One-cycle done pulse registered with the final rotate
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            done <= 1'b0;
        end else begin
            done <= last_tick;
        end
    end

endmodule

// File: tb/tb_flash_shift_engine.sv
// Self-checking bench for flash_shift_engine: per-feature tasks with an
// expected-LED queue filled when stimulus is driven and drained per cycle.
module tb_flash_shift_engine;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   ctrl_reg = '0;
    logic [31:0]   period_reg = '0;
    logic [31:0]   pattern_reg = '0;
    logic          cfg_update = 1'b0;
    logic [LW-1:0] led;
    logic          tick;
    logic          busy;
    logic          done;
    logic [15:0]   step_count;
    logic [1:0]    debug_state;

    int            checks = 0;
    int            errors = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] exp_led;

    // Clock
    always #5 clk = ~clk;

    flash_shift_engine #(
        .LED_WIDTH(LW),
        .CNT_WIDTH(32)
    ) dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .ctrl_reg    (ctrl_reg),
        .period_reg  (period_reg),
        .pattern_reg (pattern_reg),
        .cfg_update  (cfg_update),
        .led         (led),
        .tick        (tick),
        .busy        (busy),
        .done        (done),
        .step_count  (step_count),
        .debug_state (debug_state)
    );

    function automatic logic [LW-1:0] rotl(input logic [LW-1:0] v, input int n);
        logic [LW-1:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[LW-2:0], r[LW-1]};
        return r;
    endfunction

    function automatic logic [LW-1:0] rotr(input logic [LW-1:0] v, input int n);
        logic [LW-1:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[LW-1:1]};
        return r;
    endfunction

    // Driver: present registers with the strobe, sampled at the next edge
    task automatic strobe(input logic [31:0] c, input logic [31:0] p, input logic [31:0] pat);
        ctrl_reg    = c;
        period_reg  = p;
        pattern_reg = pat;
        cfg_update  = 1'b1;
        @(posedge clk);
        #1 cfg_update = 1'b0;
    endtask

    // Driver: change register inputs without any strobe
    task automatic noise();
        ctrl_reg    = $urandom;
        period_reg  = $urandom_range(0, 5);
        pattern_reg = $urandom;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (led !== '0) begin errors++; $display("FAIL reset_led got %h exp 00", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_step got %0d exp 0", step_count); end
        checks++; if (debug_state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d exp 0", debug_state); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            noise();
            exp_q.push_back('0);
            @(negedge clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL idle_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy c=%0d got %b exp 0", c, busy); end
            checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL idle_step c=%0d got %0d exp 0", c, step_count); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flash();
        for (int c = 0; c < 16; c++) exp_q.push_back(((c / 4) % 2) ? 8'h00 : 8'hA5);
        strobe(32'h2, 32'd3, 32'hA5);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL flash_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (tick !== (c % 4 == 3)) begin errors++; $display("FAIL flash_tick c=%0d got %b", c, tick); end
            checks++; if (step_count !== 16'(c / 4)) begin errors++; $display("FAIL flash_step c=%0d got %0d exp %0d", c, step_count, c / 4); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flash_busy c=%0d got %b exp 1", c, busy); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_static();
        for (int c = 0; c < 5; c++) exp_q.push_back(8'h5A);
        strobe(32'h1, 32'd0, 32'hFFFF_FF5A);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL static_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (step_count !== 16'(c)) begin errors++; $display("FAIL static_step c=%0d got %0d exp %0d", c, step_count, c); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_shift_left();
        for (int c = 0; c < 12; c++) exp_q.push_back(rotl(8'h81, c));
        strobe(32'h3, 32'd0, 32'h81);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL shl_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (tick !== 1'b1) begin errors++; $display("FAIL shl_tick c=%0d got %b exp 1", c, tick); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_oneshot();
        int done_cnt;
        done_cnt = 0;
        for (int c = 0; c < 22; c++) exp_q.push_back(rotr(8'h01, (c / 2 > 8) ? 8 : c / 2));
        strobe(32'hF, 32'd1, 32'h01);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            exp_led = exp_q.pop_front();
            if (done === 1'b1) done_cnt++;
            checks++; if (led !== exp_led) begin errors++; $display("FAIL oneshot_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (busy !== (c <= 15)) begin errors++; $display("FAIL oneshot_busy c=%0d got %b", c, busy); end
            checks++; if (done !== (c == 16)) begin errors++; $display("FAIL oneshot_done c=%0d got %b", c, done); end
            checks++; if (tick !== ((c <= 15) && (c % 2 == 1))) begin errors++; $display("FAIL oneshot_tick c=%0d got %b", c, tick); end
            @(posedge clk);
            #1;
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL oneshot_done_count got %0d exp 1", done_cnt); end
        checks++; if (step_count !== 16'd8) begin errors++; $display("FAIL oneshot_step got %0d exp 8", step_count); end
    endtask

    task automatic test_update_on_tick();
        for (int c = 0; c < 8; c++) exp_q.push_back(rotl(8'h0F, c / 3));
        strobe(32'h3, 32'd2, 32'h0F);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL upd_pre_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (tick !== (c % 3 == 2)) begin errors++; $display("FAIL upd_pre_tick c=%0d got %b", c, tick); end
            @(posedge clk);
            #1;
        end
        // Cycle 8 carries the third tick; strobe lands on the same edge
        @(negedge clk);
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL upd_third_tick got %b exp 1", tick); end
        checks++; if (step_count !== 16'd2) begin errors++; $display("FAIL upd_third_step got %0d exp 2", step_count); end
        for (int c = 0; c < 6; c++) exp_q.push_back(rotl(8'h11, c / 3));
        strobe(32'h3, 32'd2, 32'h11);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL upd_post_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (tick !== (c % 3 == 2)) begin errors++; $display("FAIL upd_post_tick c=%0d got %b", c, tick); end
            checks++; if (step_count !== 16'(c / 3)) begin errors++; $display("FAIL upd_post_step c=%0d got %0d exp %0d", c, step_count, c / 3); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_off();
        strobe(32'h0, 32'd0, 32'hFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (led !== 8'h00) begin errors++; $display("FAIL off_led c=%0d got %h exp 00", c, led); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL off_busy c=%0d got %b exp 0", c, busy); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        strobe(32'h2, 32'd1, 32'hFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %b exp 1", busy); end
        #1 rst = 1'b1;
        #1;
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL arst_led got %h exp 00", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL arst_tick got %b exp 0", tick); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL arst_step got %0d exp 0", step_count); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            noise();
            exp_q.push_back('0);
            @(negedge clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL arst_idle_led c=%0d got %h exp %h", c, led, exp_led); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle_busy c=%0d got %b exp 0", c, busy); end
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL arst_idle_tick c=%0d got %b exp 0", c, tick); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_flash();
        test_static();
        test_shift_left();
        test_oneshot();
        test_update_on_tick();
        test_off();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_shift_engine.md
# flash_shift_engine

Pattern engine downstream of the flash_shift_ip AXI4-Lite register file. It takes the software-written CTRL, PERIOD and PATTERN registers, shadows them on a register-file update strobe, and drives the board LEDs. Four modes are supported: off, static, flash and rotating shift, all paced by a programmable prescaler. The block has no bus logic; it consumes register values and one strobe only.

## Interface
- LED_WIDTH, 8, number of LED outputs (2..32)
- CNT_WIDTH, 32, prescaler width; PERIOD register bits above CNT_WIDTH are ignored
- ACLK  in  1  clock
- ARESET  in  1  reset; asynchronous, active-high
- ctrl_reg  in  32  bits[1:0] mode (00 OFF, 01 STATIC, 10 FLASH, 11 SHIFT); bit2 direction (0 left, 1 right); bit3 one-shot; bits[31:4] ignored
- period_reg  in  32  prescaler terminal count P
- pattern_reg  in  32  LED pattern; bits[LED_WIDTH-1:0] used
- cfg_update  in  1  single-cycle strobe from the register file on any write to CTRL, PERIOD or PATTERN
- led  out  LED_WIDTH  LED drive
- tick  out  1  one-cycle pulse at each prescaler expiry while RUN
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on one-shot completion
- step_count  out  16  ticks since last cfg_update; wraps 0xFFFF→0x0000

## Operation
- Shadow set (act_ctrl, act_period, act_pattern) loads from the inputs only when cfg_update=1. Input changes without the strobe have no effect.
- FSM states: IDLE, RUN, DONE.
  - On cfg_update: next state is IDLE if mode=OFF, else RUN, from any state.
  - RUN→DONE when one-shot=1, mode=SHIFT and LED_WIDTH ticks have elapsed.
  - DONE holds until the next cfg_update.
- Prescaler: cnt counts 0..P. When cnt==P: tick, cnt←0. P=0 gives a tick every cycle. Runs only in RUN; cleared on cfg_update and outside RUN.
- LED output by mode:
  - OFF: led=0.
  - STATIC: led=pattern; ticks still count.
  - FLASH: led loads pattern on cfg_update; each tick toggles between pattern and 0.
  - SHIFT: led loads pattern on cfg_update; each tick rotates one position (left: led←{led[W-2:0],led[W-1]}; right: mirror).
- One-shot applies to SHIFT only; it is ignored in other modes.
  - At DONE entry, led equals the original pattern, because LED_WIDTH rotations are a full cycle.
  - done pulses for one cycle and led holds.
- step_count increments on every tick and clears on cfg_update.

## Timing
- Reset (async assert, sync deassert by the integrator): led=0, tick=0, busy=0, done=0, step_count=0, cnt=0, shadow regs=0, state IDLE.
- cfg_update sampled at edge k: new led value and busy are visible after edge k.
- First tick is asserted during cycle k+P+1, and the led change is visible after that edge. The tick period is P+1 cycles.
- tick, led update and step_count increment occur on the same edge.
- cfg_update coincident with a prescaler expiry: the update wins. No tick, no rotate, no count, and the prescaler restarts.
- The done pulse is registered together with the final rotate, so done=1 in the cycle after the last tick. busy falls on the same edge.
- ARESET mid-RUN: all outputs take reset values immediately, without waiting for ACLK.
- Changing PERIOD mid-run takes effect only via cfg_update, which restarts the sequence from pattern.

## Structure
- flash_shift_pkg holds:
  - mode encodings MODE_OFF/STATIC/FLASH/SHIFT
  - CTRL bit positions (CTRL_DIR_BIT=2, CTRL_ONESHOT_BIT=3)
  - state enum IDLE/RUN/DONE
  - register offsets (CTRL 0x0, PERIOD 0x4, PATTERN 0x8, spare 0xC), so register file and engine agree.
- One sub-module: flash_shift_prescaler, a CNT_WIDTH counter with clear, enable, terminal count and tick output. The FSM, shadow regs and LED datapath stay in the top.

## Test plan
- Reset then idle, inputs toggling without cfg_update → led=0x00, busy=0, step_count=0 throughout.
- ctrl=0x2, period=3, pattern=0xA5, strobe → led 0xA5; then 0x00 after 4 cycles, 0xA5 after 8; tick every 4 cycles; step_count=2 after 8 cycles.
- ctrl=0x3 (shift left), period=0, pattern=0x81 → led 0x03, 0x06, 0x0C… changing every cycle.
- ctrl=0xF (shift right, one-shot), period=1, pattern=0x01 → led 0x80, 0x40, …, 0x01 after 8 ticks (16 cycles); done pulses once; busy falls; led holds 0x01.
- cfg_update on the same edge as the 3rd tick (SHIFT, P=2) → no rotate, step_count=0, led=new pattern, next tick 3 cycles later.
- ARESET asserted mid-FLASH between clock edges → led=0, busy=0 before the next ACLK edge. After release, no activity until cfg_update.
